// File: rtl/sram_bus_ctrl.sv
// Registered single-byte controller for an external 8-bit asynchronous SRAM.
// Define SRAM_BUS_TURNAROUND_EN to insert a TURN cycle before a write that follows a read.
module sram_bus_ctrl #(
   parameter int ADDR_W      = 19,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata,
   output logic              ack,
   output logic              busy,
   output logic [ADDR_W-1:0] sram_a,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_d_oe,
   output logic [7:0]        sram_d_out,
   input  logic [7:0]        sram_d_in
);

`ifdef SRAM_BUS_TURNAROUND_EN
   typedef enum logic [2:0] {IDLE, RD_ACT, WR_SETUP, WR_PULSE, WR_HOLD, TURN} state_t;
`else
   typedef enum logic [2:0] {IDLE, RD_ACT, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
`endif

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

   state_t              state_reg, state_next;
   logic [3:0]          cnt_reg, cnt_next;
   logic [ADDR_W-1:0]   a_next;
   logic [7:0]          rdata_next, d_out_next;
   logic                ack_next, ce_n_next, oe_n_next, we_n_next, d_oe_next;
`ifdef SRAM_BUS_TURNAROUND_EN
   logic                last_rd_reg, last_rd_next;
`endif

   assign busy = (state_reg != IDLE);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      a_next     = sram_a;
      rdata_next = rdata;
      d_out_next = sram_d_out;
      ack_next   = 1'b0;
`ifdef SRAM_BUS_TURNAROUND_EN
      last_rd_next = last_rd_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (req) begin
               a_next   = addr;
               cnt_next = WAIT_LOAD;
               if (we) begin
                  // Pads stay disabled until WR_SETUP, so loading data early is harmless.
                  d_out_next = wdata;
`ifdef SRAM_BUS_TURNAROUND_EN
                  state_next = last_rd_reg ? TURN : WR_SETUP;
`else
                  state_next = WR_SETUP;
`endif
               end else begin
                  state_next = RD_ACT;
               end
            end
         end
         RD_ACT: begin
            if (cnt_reg == 4'd0) begin
               rdata_next = sram_d_in;
               ack_next   = 1'b1;
               state_next = IDLE;
`ifdef SRAM_BUS_TURNAROUND_EN
               last_rd_next = 1'b1;
`endif
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         WR_SETUP: begin
            cnt_next   = WAIT_LOAD;
            state_next = WR_PULSE;
         end
         WR_PULSE: begin
            if (cnt_reg == 4'd0) state_next = WR_HOLD;
            else                 cnt_next   = cnt_reg - 4'd1;
         end
         WR_HOLD: begin
            ack_next   = 1'b1;
            state_next = IDLE;
`ifdef SRAM_BUS_TURNAROUND_EN
            last_rd_next = 1'b0;
`endif
         end
`ifdef SRAM_BUS_TURNAROUND_EN
         TURN: state_next = WR_SETUP;
`endif
         default: state_next = IDLE;
      endcase

      // Pin strobes are decoded from the next state so they are registered with it.
      ce_n_next = !((state_next == RD_ACT) || (state_next == WR_SETUP) ||
                    (state_next == WR_PULSE) || (state_next == WR_HOLD));
      oe_n_next = (state_next != RD_ACT);
      we_n_next = (state_next != WR_PULSE);
      d_oe_next = (state_next == WR_SETUP) || (state_next == WR_PULSE) ||
                  (state_next == WR_HOLD);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= 4'd0;
         sram_a     <= '0;
         rdata      <= 8'd0;
         sram_d_out <= 8'd0;
         ack        <= 1'b0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         sram_d_oe  <= 1'b0;
`ifdef SRAM_BUS_TURNAROUND_EN
         last_rd_reg <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         sram_a     <= a_next;
         rdata      <= rdata_next;
         sram_d_out <= d_out_next;
         ack        <= ack_next;
         sram_ce_n  <= ce_n_next;
         sram_oe_n  <= oe_n_next;
         sram_we_n  <= we_n_next;
         sram_d_oe  <= d_oe_next;
`ifdef SRAM_BUS_TURNAROUND_EN
         last_rd_reg <= last_rd_next;
`endif
      end
   end

endmodule
